// File: rtl/scc_i2s_out.sv
`default_nettype none
// ============================================================================
//  Module   : scc_i2s_out
//  Brief    : Serialises the SCC core's 11-bit signed sound output as a
//             mono-duplicated, 16-bit, Philips-format I2S stream. BCLK and
//             LRCLK are derived from the system clock; one sample is captured
//             per 32-BCLK frame.
//  Revision : 1.0 - initial release
// ============================================================================
module scc_i2s_out #(
    parameter int BCLK_HALF = 8            // clk cycles per BCLK half-period, 1..255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] sound_in,
    input  logic        mute,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_sdata,
    output logic        sample_req
);

    localparam logic [7:0] c_div_max = 8'(BCLK_HALF - 1);

    logic [7:0]  r_div_cnt;
    logic        r_bclk;
    logic        r_lrclk;
    logic        r_sdata;
    logic        r_sample_req;
    logic [4:0]  r_bit_cnt;
    logic [31:0] r_frame;

    logic        w_div_wrap;
    logic        w_fall;
    logic [4:0]  w_n;
    logic [4:0]  w_bit_idx;
    logic [15:0] w_word;

    // Divider wrap point; a wrap while BCLK is high is the falling event that
    // advances the whole serialiser.
    assign w_div_wrap = (r_div_cnt == c_div_max);
    assign w_fall     = w_div_wrap & r_bclk;

    // Next bit position, and the frame bit it selects: 32-n for n in 1..31,
    // which wraps to index 0 at n==0 (previous frame's right LSB).
    assign w_n       = r_bit_cnt + 5'd1;
    assign w_bit_idx = 5'd0 - w_n;

    // Left-justified sample word; the sign bit lands on word[15].
    assign w_word = mute ? 16'h0000 : {sound_in, 5'b00000};

    // Bit-clock divider: count half-periods and toggle BCLK at each wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= 8'd0;
            r_bclk    <= 1'b0;
        end else if (w_div_wrap) begin
            r_div_cnt <= 8'd0;
            r_bclk    <= ~r_bclk;
        end else begin
            r_div_cnt <= r_div_cnt + 8'd1;
        end
    end

    // Bit position, word select and serial data all advance on the falling event.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt <= 5'd31;
            r_lrclk   <= 1'b0;
            r_sdata   <= 1'b0;
        end else if (w_fall) begin
            r_bit_cnt <= w_n;
            r_lrclk   <= w_n[4];
            r_sdata   <= r_frame[w_bit_idx];
        end
    end

    // Frame capture at bit position 0; the old frame[0] is read in the same
    // cycle by the data register above, so the overwrite here is safe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame      <= 32'h0;
            r_sample_req <= 1'b0;
        end else begin
            r_sample_req <= 1'b0;
            if (w_fall && (w_n == 5'd0)) begin
                r_frame      <= {w_word, w_word};
                r_sample_req <= 1'b1;
            end
        end
    end

    assign i2s_bclk   = r_bclk;
    assign i2s_lrclk  = r_lrclk;
    assign i2s_sdata  = r_sdata;
    assign sample_req = r_sample_req;

endmodule
`default_nettype wire

// File: tb/tb_scc_i2s_out.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scc_i2s_out
//  Brief    : Directed self-checking bench for scc_i2s_out (BCLK_HALF=8 main
//             instance, plus a BCLK_HALF=1 instance for divider edge cases).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_scc_i2s_out;

    logic        clk;
    logic        reset;
    logic [10:0] sound_in;
    logic        mute;
    logic        bclk, lrclk, sdata, sample_req;
    logic        bclk1, lrclk1, sdata1, req1;

    int total;
    int passed;

    scc_i2s_out #(.BCLK_HALF(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .sound_in   (sound_in),
        .mute       (mute),
        .i2s_bclk   (bclk),
        .i2s_lrclk  (lrclk),
        .i2s_sdata  (sdata),
        .sample_req (sample_req)
    );

    scc_i2s_out #(.BCLK_HALF(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .sound_in   (sound_in),
        .mute       (mute),
        .i2s_bclk   (bclk1),
        .i2s_lrclk  (lrclk1),
        .i2s_sdata  (sdata1),
        .sample_req (req1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    // Step until BCLK is seen falling (bounded); counts clk steps and sample_req highs.
    task automatic wait_fall(output logic ok, output int c, inout int pulses);
        logic prev;
        ok = 1'b0;
        c  = 0;
        for (int k = 0; k < 40; k++) begin
            prev = bclk;
            step();
            c++;
            if (sample_req) pulses++;
            if (prev && !bclk) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Starting at a capture point, collect the 32 bits of the captured frame
    // and end on the next capture point.
    task automatic run_frame(input string tag, input int chg_at, input logic [10:0] chg_val,
                             input logic [31:0] exp_data);
        logic [31:0] data, lr;
        int clks, pulses, c;
        logic ok, per_ok;
        clks = 0; pulses = 0; per_ok = 1'b1;
        data = '0; lr = '0;
        for (int i = 0; i < 32; i++) begin
            if (i == chg_at) sound_in = chg_val;
            wait_fall(ok, c, pulses);
            clks += c;
            if (!ok || c != 16) per_ok = 1'b0;
            data[31-i] = sdata;
            lr[31-i]   = lrclk;
        end
        check({tag, "_data"},   data,   exp_data);
        check({tag, "_lrclk"},  lr,     32'h0001FFFE);
        check({tag, "_bclk16"}, 32'(per_ok), 32'd1);
        check({tag, "_clks"},   clks,   32'd512);
        check({tag, "_pulses"}, pulses, 32'd1);
        check({tag, "_reqend"}, 32'(sample_req), 32'd1);
    endtask

    initial begin
        int k, first0, p1a, p1b;
        logic ok, alt_ok;
        int c, pulses;
        total = 0; passed = 0;
        reset = 1'b1; sound_in = 11'h3FF; mute = 1'b0;
        step(); step(); step();
        check("rst_bclk",   32'(bclk),        32'd0);
        check("rst_lrclk",  32'(lrclk),       32'd0);
        check("rst_sdata",  32'(sdata),       32'd0);
        check("rst_req",    32'(sample_req),  32'd0);
        check("rst_bitcnt", 32'(dut.r_bit_cnt), 32'd31);
        reset = 1'b0;

        // First capture event: 2*BCLK_HALF clk after release.
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (sample_req) begin k = i; break; end
        end
        check("first_req", k, 32'd16);

        sound_in = 11'h400;
        run_frame("f3ff", -1, 11'h0, 32'h7FE0_7FE0);
        mute = 1'b1; sound_in = 11'h155;
        run_frame("f400", -1, 11'h0, 32'h8000_8000);
        mute = 1'b0;
        run_frame("fmute", -1, 11'h0, 32'h0000_0000);
        sound_in = 11'h001;
        run_frame("f155", -1, 11'h0, 32'h2AA0_2AA0);
        run_frame("f001", 8, 11'h7FF, 32'h0020_0020);
        run_frame("f7ff", -1, 11'h0, 32'hFFE0_FFE0);

        // sample_req lasts exactly one clk.
        step();
        check("req_width", 32'(sample_req), 32'd0);

        // Advance to bit_cnt==9, then reset for one clk mid BCLK phase.
        pulses = 0;
        for (int i = 0; i < 9; i++) wait_fall(ok, c, pulses);
        check("pre_bitcnt", 32'(dut.r_bit_cnt), 32'd9);
        check("pre_sdata",  32'(sdata),         32'd1);
        step(); step(); step();
        reset = 1'b1;
        step();
        check("mid_bclk",   32'(bclk),        32'd0);
        check("mid_lrclk",  32'(lrclk),       32'd0);
        check("mid_sdata",  32'(sdata),       32'd0);
        check("mid_req",    32'(sample_req),  32'd0);
        check("mid_bitcnt", 32'(dut.r_bit_cnt), 32'd31);
        reset = 1'b0;

        first0 = 0; p1a = 0; p1b = 0; alt_ok = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            step();
            if (sample_req && first0 == 0) first0 = i;
            if (req1) begin
                if (p1a == 0) p1a = i;
                else if (p1b == 0) p1b = i;
            end
            if (bclk1 !== i[0]) alt_ok = 1'b0;
        end
        check("rel_first_req", first0, 32'd16);
        check("h1_first_req",  p1a,    32'd2);
        check("h1_second_req", p1b,    32'd66);
        check("h1_bclk_alt",   32'(alt_ok), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scc_i2s_out.md
Name: scc_i2s_out

Overview:
Output stage directly downstream of the SCC sound core. It consumes the core's 11-bit two's-complement digital sound output. It serialises that sound as a mono-duplicated, 16-bit, Philips-format I2S stream for an external audio DAC/codec. The block generates its own BCLK/LRCLK from the system clock and captures one sample per frame.

Parameters:
BCLK_HALF, 8, number of clk cycles per BCLK half-period (legal 1..255); BCLK period = 2*BCLK_HALF clk, frame = 64*BCLK_HALF clk

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
sound_in  input  11  signed sample from SCC sound core (sound_out); sampled only at frame capture
mute  input  1  1 = captured sample forced to 0; sampled at frame capture only
i2s_bclk  output  1  I2S bit clock
i2s_lrclk  output  1  I2S word select; 0 = left, 1 = right
i2s_sdata  output  1  I2S serial data, MSB first, changes on BCLK falling edge
sample_req  output  1  one-clk pulse at each frame capture

Behaviour:
- One clock, synchronous active-high reset. All outputs are registered; no combinational path from inputs to outputs.
- Reset values:
  - div_cnt=0, i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0, sample_req=0
  - bit_cnt=31, frame register=32'h0
- Divider:
  - div_cnt counts 0..BCLK_HALF-1.
  - At div_cnt==BCLK_HALF-1: div_cnt<=0 and i2s_bclk toggles; otherwise div_cnt increments.
- Falling event F: the clk edge on which i2s_bclk goes 1->0. All state below advances only at F.
- At F:
  - bit_cnt <= bit_cnt+1 mod 32. Let n be the new value.
  - i2s_lrclk <= n[4].
- Data at F:
  - n==0: i2s_sdata <= frame[0] (previous frame's right LSB).
  - n in 1..31: i2s_sdata <= frame[32-n].
  - Frame bit order is {L[15:0],R[15:0]}, so L[15] is frame[31] and is driven at n=1.
  - Result: MSB lags each LRCLK transition by one BCLK, as standard I2S requires.
- Capture at F with n==0, after frame[0] has been used for i2s_sdata:
  - word = mute ? 16'h0000 : {sound_in, 5'b00000} (left-justified; sign preserved because sound_in[10] becomes word[15]).
  - frame <= {word, word}, so left and right are identical.
  - sample_req=1 for exactly that clk cycle; 0 otherwise.
- Frame timing: first F after reset is the capture event (bit_cnt wraps 31->0). The first frame's left MSB appears at the second F.
- Width rule: no saturation or rounding. 11-bit input maps exactly onto the 16-bit word.
- sound_in and mute changing mid-frame have no effect until the next capture.
- Reset asserted mid-frame: on the next clk all state returns to reset values. i2s_bclk may be truncated; no glitch beyond that single truncated BCLK phase.
- BCLK_HALF==1: i2s_bclk toggles every clk (BCLK = clk/2). All rules above still hold.

Test Plan:
- Reset, BCLK_HALF=8, sound_in=11'h3FF, mute=0 -> i2s_bclk period 16 clk; sample_req every 512 clk; left and right words serialised as 16'h7FE0.
- sound_in=11'h400 -> both words 16'h8000: sdata 1 at n=1 then 0 for n=2..16; same pattern at n=17 (MSB) then 0 to end of frame.
- LRCLK framing -> lrclk falls at the F where sample_req pulses. lrclk rises 16 BCLK later. Each MSB appears one BCLK after the lrclk edge.
- mute=1 for one frame with sound_in=11'h155 -> that frame all zeros. sample_req still pulses. Next frame after mute=0 carries 16'h2AA0.
- Change sound_in from 11'h001 to 11'h7FF mid-frame -> current frame stays 16'h0020 in both halves. Next frame is 16'hFFE0.
- Assert reset for 1 clk at bit_cnt=9 -> next cycle all outputs 0 and bit_cnt=31. First sample_req comes 2*BCLK_HALF clk after reset release.
